// File: rtl/i2c_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | i2c_pkg : shared state and byte-engine op encodings for I2C       |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package i2c_pkg;

  localparam logic [3:0] ST_IDLE  = 4'd0;
  localparam logic [3:0] ST_SNAP  = 4'd1;
  localparam logic [3:0] ST_ADDR  = 4'd2;
  localparam logic [3:0] ST_FETCH = 4'd3;
  localparam logic [3:0] ST_WR    = 4'd4;
  localparam logic [3:0] ST_RD    = 4'd5;
  localparam logic [3:0] ST_STOP  = 4'd6;
  localparam logic [3:0] ST_RETRY = 4'd7;
  localparam logic [3:0] ST_DRAIN = 4'd8;
  localparam logic [3:0] ST_FIN   = 4'd9;

  localparam logic [1:0] OP_START = 2'd0;
  localparam logic [1:0] OP_WRITE = 2'd1;
  localparam logic [1:0] OP_READ  = 2'd2;
  localparam logic [1:0] OP_STOP  = 2'd3;

  function automatic logic [7:0] addr_byte(input logic [6:0] addr, input logic rw);
    return {addr, rw};
  endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_xfer_seq.sv
`default_nettype none
// +------------------------------------------------------------------+
// | i2c_xfer_seq : command sequencer between TX/RX FIFOs and the I2C  |
// | byte engine, with snapshot/rollback retry.  Rev 1.0               |
// +------------------------------------------------------------------+
module i2c_xfer_seq
  import i2c_pkg::*;
#(
  parameter int MAX_RETRY = 3,
  parameter int LEN_W     = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_rw,
  input  logic [6:0]       cmd_addr,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             tx_rd_en,
  input  logic [7:0]       tx_rd_data,
  input  logic             tx_empty,
  output logic             tx_snapshot,
  output logic             tx_rollback,
  output logic             rx_wr_en,
  output logic [7:0]       rx_wr_data,
  input  logic             rx_full,
  output logic             rx_snapshot,
  output logic             rx_rollback,
  output logic             eng_req,
  output logic [1:0]       eng_op,
  output logic [7:0]       eng_wdata,
  output logic             eng_nack_last,
  input  logic             eng_done,
  input  logic             eng_ack,
  input  logic             eng_arb_lost,
  input  logic [7:0]       eng_rdata,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [1:0]       retry_cnt
);

  localparam logic [1:0] c_max_retry = 2'(MAX_RETRY);

  logic [3:0]       r_state;
  logic [1:0]       r_ph;      // sub-phase: issue / wait (WR adds a fetch-latency phase)
  logic             r_rw;
  logic [6:0]       r_addr;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_rem;
  logic             r_failed;

  logic w_accept;
  logic w_last;

  assign w_accept = (r_state == ST_IDLE) && cmd_ready && cmd_valid;
  assign w_last   = (r_rem == LEN_W'(1));
  assign busy     = (r_state != ST_IDLE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state       <= ST_IDLE;
      r_ph          <= 2'd0;
      r_rw          <= 1'b0;
      r_addr        <= 7'd0;
      r_len         <= '0;
      r_rem         <= '0;
      r_failed      <= 1'b0;
      cmd_ready     <= 1'b0;
      tx_rd_en      <= 1'b0;
      tx_snapshot   <= 1'b0;
      tx_rollback   <= 1'b0;
      rx_wr_en      <= 1'b0;
      rx_wr_data    <= 8'd0;
      rx_snapshot   <= 1'b0;
      rx_rollback   <= 1'b0;
      eng_req       <= 1'b0;
      eng_op        <= 2'd0;
      eng_wdata     <= 8'd0;
      eng_nack_last <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      retry_cnt     <= 2'd0;
    end else begin
      tx_rd_en    <= 1'b0;
      tx_snapshot <= 1'b0;
      tx_rollback <= 1'b0;
      rx_wr_en    <= 1'b0;
      rx_snapshot <= 1'b0;
      rx_rollback <= 1'b0;
      eng_req     <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          cmd_ready <= !w_accept;
          if (w_accept) begin
            r_rw      <= cmd_rw;
            r_addr    <= cmd_addr;
            r_len     <= cmd_len;
            retry_cnt <= 2'd0;
            r_state   <= ST_SNAP;
          end
        end
        ST_SNAP: begin
          tx_snapshot <= 1'b1;
          rx_snapshot <= 1'b1;
          r_rem       <= r_len;
          r_failed    <= 1'b0;
          r_ph        <= 2'd0;
          r_state     <= ST_ADDR;
        end
        ST_ADDR: begin
          if (r_ph == 2'd0) begin
            eng_req       <= 1'b1;
            eng_op        <= OP_START;
            eng_wdata     <= addr_byte(r_addr, r_rw);
            eng_nack_last <= 1'b0;
            r_ph          <= 2'd1;
          end else if (eng_done) begin
            r_ph <= 2'd0;
            // Arbitration loss wins over ACK and leaves the bus to the winner: no STOP.
            if (eng_arb_lost) begin
              r_failed <= 1'b1;
              r_state  <= ST_RETRY;
            end else if (!eng_ack) begin
              r_failed <= 1'b1;
              r_state  <= ST_STOP;
            end else if (r_len == '0) begin
              r_state <= ST_STOP;
            end else begin
              r_state <= r_rw ? ST_RD : ST_FETCH;
            end
          end
        end
        ST_FETCH: begin
          if (!tx_empty) begin
            tx_rd_en <= 1'b1;
            r_ph     <= 2'd0;
            r_state  <= ST_WR;
          end
        end
        ST_WR: begin
          case (r_ph)
            2'd0: r_ph <= 2'd1;
            2'd1: begin
              eng_req       <= 1'b1;
              eng_op        <= OP_WRITE;
              eng_wdata     <= tx_rd_data;
              eng_nack_last <= 1'b0;
              r_ph          <= 2'd2;
            end
            default: begin
              if (eng_done) begin
                r_ph <= 2'd0;
                if (eng_arb_lost) begin
                  r_failed <= 1'b1;
                  r_state  <= ST_RETRY;
                end else if (eng_ack || w_last) begin
                  r_rem   <= r_rem - LEN_W'(1);
                  r_state <= w_last ? ST_STOP : ST_FETCH;
                end else begin
                  r_failed <= 1'b1;
                  r_state  <= ST_STOP;
                end
              end
            end
          endcase
        end
        ST_RD: begin
          if (r_ph == 2'd0) begin
            if (!rx_full) begin
              eng_req       <= 1'b1;
              eng_op        <= OP_READ;
              eng_nack_last <= w_last;
              r_ph          <= 2'd1;
            end
          end else if (eng_done) begin
            r_ph <= 2'd0;
            if (eng_arb_lost) begin
              r_failed <= 1'b1;
              r_state  <= ST_RETRY;
            end else begin
              rx_wr_en   <= 1'b1;
              rx_wr_data <= eng_rdata;
              r_rem      <= r_rem - LEN_W'(1);
              if (w_last) r_state <= ST_STOP;
            end
          end
        end
        ST_STOP: begin
          if (r_ph == 2'd0) begin
            eng_req       <= 1'b1;
            eng_op        <= OP_STOP;
            eng_nack_last <= 1'b0;
            r_ph          <= 2'd1;
          end else if (eng_done) begin
            r_ph    <= 2'd0;
            r_state <= r_failed ? ST_RETRY : ST_FIN;
          end
        end
        ST_RETRY: begin
          tx_rollback <= 1'b1;
          rx_rollback <= 1'b1;
          r_ph        <= 2'd0;
          if (retry_cnt == c_max_retry) begin
            r_rem   <= r_rw ? '0 : r_len;
            r_state <= ST_DRAIN;
          end else begin
            retry_cnt <= retry_cnt + 2'd1;
            r_state   <= ST_SNAP;
          end
        end
        ST_DRAIN: begin
          // Idle one cycle after each pop so tx_empty reflects it before the next.
          if (r_ph != 2'd0) begin
            r_ph <= 2'd0;
          end else if (r_rem == '0) begin
            r_state <= ST_FIN;
          end else if (!tx_empty) begin
            tx_rd_en <= 1'b1;
            r_rem    <= r_rem - LEN_W'(1);
            r_ph     <= 2'd1;
          end
        end
        ST_FIN: begin
          done      <= !r_failed;
          err       <= r_failed;
          cmd_ready <= 1'b1;
          r_state   <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_i2c_xfer_seq.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_i2c_xfer_seq : scoreboard bench with FIFO and byte-engine      |
// | models.  Rev 1.0                                                  |
// +------------------------------------------------------------------+
module tb_i2c_xfer_seq;
  import i2c_pkg::*;

  typedef struct packed {
    logic [1:0] op;
    logic [7:0] wdata;
    logic       nl;
  } op_t;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       cmd_valid = 1'b0, cmd_ready, cmd_rw = 1'b0;
  logic [6:0] cmd_addr = 7'd0;
  logic [7:0] cmd_len = 8'd0;
  logic       tx_rd_en, tx_empty, tx_snapshot, tx_rollback;
  logic [7:0] tx_rd_data = 8'd0;
  logic       rx_wr_en, rx_full = 1'b0, rx_snapshot, rx_rollback;
  logic [7:0] rx_wr_data;
  logic       eng_req, eng_nack_last;
  logic [1:0] eng_op;
  logic [7:0] eng_wdata;
  logic       eng_done, eng_ack, eng_arb_lost;
  logic [7:0] eng_rdata;
  logic       busy, done, err;
  logic [1:0] retry_cnt;

  int checks = 0;
  int errors = 0;

  i2c_xfer_seq #(.MAX_RETRY(3), .LEN_W(8)) dut (
    .clk(clk), .rstn(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .tx_rd_en(tx_rd_en), .tx_rd_data(tx_rd_data), .tx_empty(tx_empty),
    .tx_snapshot(tx_snapshot), .tx_rollback(tx_rollback),
    .rx_wr_en(rx_wr_en), .rx_wr_data(rx_wr_data), .rx_full(rx_full),
    .rx_snapshot(rx_snapshot), .rx_rollback(rx_rollback),
    .eng_req(eng_req), .eng_op(eng_op), .eng_wdata(eng_wdata),
    .eng_nack_last(eng_nack_last), .eng_done(eng_done), .eng_ack(eng_ack),
    .eng_arb_lost(eng_arb_lost), .eng_rdata(eng_rdata),
    .busy(busy), .done(done), .err(err), .retry_cnt(retry_cnt)
  );

  always #5 clk = ~clk;

  // TX FIFO model with read-pointer snapshot/rollback
  logic [7:0] txmem [0:255];
  int   tx_wp = 0, tx_rp = 0, tx_snap = 0;
  logic tx_hold = 1'b0, tx_clr = 1'b0;
  assign tx_empty = (tx_rp == tx_wp) || tx_hold;
  always @(posedge clk) begin
    if (tx_clr) begin
      tx_rp   <= tx_wp;
      tx_snap <= tx_wp;
    end else begin
      if (tx_rd_en) begin
        tx_rd_data <= txmem[tx_rp];
        tx_rp      <= tx_rp + 1;
      end
      if (tx_snapshot) tx_snap <= tx_rp;
      if (tx_rollback) tx_rp <= tx_snap;
    end
  end

  // RX FIFO model with write-pointer snapshot/rollback
  logic [7:0] rxmem [0:255];
  int rx_wp = 0, rx_snap = 0;
  always @(posedge clk) begin
    if (rx_wr_en) begin
      rxmem[rx_wp] <= rx_wr_data;
      rx_wp        <= rx_wp + 1;
    end
    if (rx_snapshot) rx_snap <= rx_wp;
    if (rx_rollback) rx_wp <= rx_snap;
  end

  // Byte-engine model: done 3 cycles after req, responses scripted by op counters
  int addr_ops = 0, wr_ops = 0, rd_ops = 0;
  int nack_addr_until = 0, nack_wr_at = -1, arb_rd_at = -1;
  int pend = 0;
  logic r_ack, r_arb;
  logic [7:0] r_rdata;
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pend <= 0; eng_done <= 1'b0; eng_ack <= 1'b0; eng_arb_lost <= 1'b0;
      eng_rdata <= 8'd0; r_ack <= 1'b0; r_arb <= 1'b0; r_rdata <= 8'd0;
    end else begin
      eng_done     <= 1'b0;
      eng_arb_lost <= 1'b0;
      if (eng_req) begin
        pend <= 2; r_ack <= 1'b1; r_arb <= 1'b0; r_rdata <= 8'd0;
        case (eng_op)
          OP_START: begin
            addr_ops <= addr_ops + 1;
            if (addr_ops < nack_addr_until) r_ack <= 1'b0;
          end
          OP_WRITE: begin
            wr_ops <= wr_ops + 1;
            if (wr_ops == nack_wr_at) r_ack <= 1'b0;
          end
          OP_READ: begin
            rd_ops  <= rd_ops + 1;
            r_rdata <= 8'(rd_ops) ^ 8'h5A;
            if (rd_ops == arb_rd_at) r_arb <= 1'b1;
          end
          default: ;
        endcase
      end else if (pend == 2) begin
        pend <= 1;
      end else if (pend == 1) begin
        pend <= 0; eng_done <= 1'b1; eng_ack <= r_ack;
        eng_arb_lost <= r_arb; eng_rdata <= r_rdata;
      end
    end
  end

  // Output monitor: records issued engine ops and pulse counts
  op_t obs_q[$];
  op_t exp_q[$];
  int n_txrd = 0, n_rxwr = 0, n_rb = 0, n_rb_bad = 0, n_done = 0, n_err = 0, n_req_long = 0;
  logic prev_req = 1'b0;
  always @(negedge clk) begin
    if (eng_req)
      obs_q.push_back('{eng_op,
                        (eng_op == OP_START || eng_op == OP_WRITE) ? eng_wdata : 8'h00,
                        (eng_op == OP_READ) ? eng_nack_last : 1'b0});
    if (eng_req && prev_req) n_req_long++;
    prev_req = eng_req;
    if (tx_rollback || rx_rollback) begin
      n_rb++;
      if (tx_rollback !== rx_rollback || tx_rd_en || rx_wr_en) n_rb_bad++;
    end
    if (tx_rd_en) n_txrd++;
    if (rx_wr_en) n_rxwr++;
    if (done) n_done++;
    if (err) n_err++;
  end

  op_t e, o;

  task automatic push_tx(input logic [7:0] b);
    txmem[tx_wp] = b;
    tx_wp++;
  endtask

  task automatic exp_op(input logic [1:0] op, input logic [7:0] wd, input logic nl);
    exp_q.push_back('{op, wd, nl});
  endtask

  task automatic send_cmd(input logic rw, input logic [6:0] a, input logic [7:0] len);
    @(negedge clk);
    cmd_rw = rw; cmd_addr = a; cmd_len = len; cmd_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy) break;
    end
    cmd_valid = 1'b0;
  endtask

  task automatic wait_fin(input string name);
    int start;
    start = n_done + n_err;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk); #1;
      if (n_done + n_err > start) break;
    end
    checks++;
    if (n_done + n_err == start) begin
      errors++;
      $display("FAIL %s_timeout: got no done/err pulse, required one within 2000 cycles", name);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({cmd_ready, busy, done, err, eng_req, tx_rd_en, tx_snapshot, tx_rollback, rx_wr_en,
         rx_snapshot, rx_rollback, retry_cnt, eng_op, eng_wdata, rx_wr_data, eng_nack_last} !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: got cmd_ready %b busy %b eng_req %b, required all 0", cmd_ready, busy, eng_req);
    end
    rstn = 1'b1;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: got cmd_ready %b busy %b, required 1 0", cmd_ready, busy);
    end
  endtask

  task automatic test_write();
    int ob = obs_q.size(), t0 = n_txrd, r0 = n_rb, d0 = n_done, e0 = n_err, k = 0;
    push_tx(8'hA1); push_tx(8'hA2); push_tx(8'hA3);
    exp_op(OP_START, 8'hA0, 0); exp_op(OP_WRITE, 8'hA1, 0); exp_op(OP_WRITE, 8'hA2, 0);
    exp_op(OP_WRITE, 8'hA3, 0); exp_op(OP_STOP, 8'h00, 0);
    send_cmd(1'b0, 7'h50, 8'd3);
    wait_fin("write");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (ob + k < obs_q.size()) ? obs_q[ob + k] : '1;
      checks++;
      if (o !== e) begin errors++; $display("FAIL write_op%0d: got op %0d wdata %02h nl %b, required op %0d wdata %02h nl %b", k, o.op, o.wdata, o.nl, e.op, e.wdata, e.nl); end
      k++;
    end
    checks++;
    if (obs_q.size() - ob != k || n_txrd - t0 != 3 || n_rb != r0 || n_done - d0 != 1 || n_err != e0) begin
      errors++;
      $display("FAIL write_counts: got ops %0d rd_en %0d rollback %0d done %0d err %0d, required 5 3 0 1 0",
               obs_q.size() - ob, n_txrd - t0, n_rb - r0, n_done - d0, n_err - e0);
    end
  endtask

  task automatic test_read();
    int ob = obs_q.size(), base = rx_wp, rb = rd_ops, d0 = n_done, w0 = n_rxwr, k = 0;
    exp_op(OP_START, 8'hD1, 0); exp_op(OP_READ, 8'h00, 0); exp_op(OP_READ, 8'h00, 1); exp_op(OP_STOP, 8'h00, 0);
    send_cmd(1'b1, 7'h68, 8'd2);
    wait_fin("read");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (ob + k < obs_q.size()) ? obs_q[ob + k] : '1;
      checks++;
      if (o !== e) begin errors++; $display("FAIL read_op%0d: got op %0d wdata %02h nl %b, required op %0d wdata %02h nl %b", k, o.op, o.wdata, o.nl, e.op, e.wdata, e.nl); end
      k++;
    end
    checks++;
    if (obs_q.size() - ob != k || n_rxwr - w0 != 2 || rx_wp - base != 2 || n_done - d0 != 1) begin
      errors++;
      $display("FAIL read_counts: got ops %0d wr_en %0d rx_level %0d done %0d, required 4 2 2 1",
               obs_q.size() - ob, n_rxwr - w0, rx_wp - base, n_done - d0);
    end
    checks++;
    if (rxmem[base] !== (8'(rb) ^ 8'h5A) || rxmem[base + 1] !== (8'(rb + 1) ^ 8'h5A)) begin
      errors++;
      $display("FAIL read_data: got %02h %02h, required %02h %02h", rxmem[base], rxmem[base + 1],
               8'(rb) ^ 8'h5A, 8'(rb + 1) ^ 8'h5A);
    end
  endtask

  task automatic test_nack_retry();
    int ob = obs_q.size(), t0 = n_txrd, r0 = n_rb, rbad = n_rb_bad, d0 = n_done, k = 0;
    nack_wr_at = wr_ops;
    push_tx(8'hB1); push_tx(8'hB2);
    exp_op(OP_START, 8'h44, 0); exp_op(OP_WRITE, 8'hB1, 0); exp_op(OP_STOP, 8'h00, 0);
    exp_op(OP_START, 8'h44, 0); exp_op(OP_WRITE, 8'hB1, 0); exp_op(OP_WRITE, 8'hB2, 0); exp_op(OP_STOP, 8'h00, 0);
    send_cmd(1'b0, 7'h22, 8'd2);
    wait_fin("nack_retry");
    nack_wr_at = -1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (ob + k < obs_q.size()) ? obs_q[ob + k] : '1;
      checks++;
      if (o !== e) begin errors++; $display("FAIL nack_op%0d: got op %0d wdata %02h nl %b, required op %0d wdata %02h nl %b", k, o.op, o.wdata, o.nl, e.op, e.wdata, e.nl); end
      k++;
    end
    checks++;
    if (obs_q.size() - ob != k || n_txrd - t0 != 3 || n_rb - r0 != 1 || n_rb_bad != rbad ||
        n_done - d0 != 1 || retry_cnt !== 2'd1) begin
      errors++;
      $display("FAIL nack_counts: got ops %0d rd_en %0d rollback %0d bad %0d done %0d retry %0d, required 7 3 1 0 1 1",
               obs_q.size() - ob, n_txrd - t0, n_rb - r0, n_rb_bad - rbad, n_done - d0, retry_cnt);
    end
  endtask

  task automatic test_addr_fail();
    int ob = obs_q.size(), t0 = n_txrd, r0 = n_rb, d0 = n_done, e0 = n_err, k = 0;
    nack_addr_until = addr_ops + 4;
    push_tx(8'hC1); push_tx(8'hC2);
    for (int i = 0; i < 4; i++) begin
      exp_op(OP_START, 8'h66, 0); exp_op(OP_STOP, 8'h00, 0);
    end
    send_cmd(1'b0, 7'h33, 8'd2);
    wait_fin("addr_fail");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (ob + k < obs_q.size()) ? obs_q[ob + k] : '1;
      checks++;
      if (o !== e) begin errors++; $display("FAIL addr_fail_op%0d: got op %0d wdata %02h, required op %0d wdata %02h", k, o.op, o.wdata, e.op, e.wdata); end
      k++;
    end
    checks++;
    if (obs_q.size() - ob != k || n_txrd - t0 != 2 || n_rb - r0 != 4 || n_err - e0 != 1 ||
        n_done != d0 || tx_empty !== 1'b1 || retry_cnt !== 2'd3) begin
      errors++;
      $display("FAIL addr_fail_counts: got ops %0d rd_en %0d rollback %0d err %0d done %0d empty %b retry %0d, required 8 2 4 1 0 1 3",
               obs_q.size() - ob, n_txrd - t0, n_rb - r0, n_err - e0, n_done - d0, tx_empty, retry_cnt);
    end
  endtask

  task automatic test_arb_read();
    int ob = obs_q.size(), base = rx_wp, rb = rd_ops, r0 = n_rb, d0 = n_done, k = 0;
    arb_rd_at = rd_ops + 1;
    exp_op(OP_START, 8'h23, 0); exp_op(OP_READ, 8'h00, 0); exp_op(OP_READ, 8'h00, 1);
    exp_op(OP_START, 8'h23, 0); exp_op(OP_READ, 8'h00, 0); exp_op(OP_READ, 8'h00, 1); exp_op(OP_STOP, 8'h00, 0);
    send_cmd(1'b1, 7'h11, 8'd2);
    wait_fin("arb_read");
    arb_rd_at = -1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (ob + k < obs_q.size()) ? obs_q[ob + k] : '1;
      checks++;
      if (o !== e) begin errors++; $display("FAIL arb_op%0d: got op %0d wdata %02h nl %b, required op %0d wdata %02h nl %b", k, o.op, o.wdata, o.nl, e.op, e.wdata, e.nl); end
      k++;
    end
    checks++;
    if (obs_q.size() - ob != k || n_rb - r0 != 1 || n_done - d0 != 1 || rx_wp - base != 2 ||
        rxmem[base] !== (8'(rb + 2) ^ 8'h5A) || rxmem[base + 1] !== (8'(rb + 3) ^ 8'h5A)) begin
      errors++;
      $display("FAIL arb_result: got ops %0d rollback %0d done %0d rx_level %0d data %02h %02h, required 7 1 1 2 %02h %02h",
               obs_q.size() - ob, n_rb - r0, n_done - d0, rx_wp - base, rxmem[base], rxmem[base + 1],
               8'(rb + 2) ^ 8'h5A, 8'(rb + 3) ^ 8'h5A);
    end
  endtask

  task automatic test_fetch_stall();
    int ob = obs_q.size(), d0 = n_done, rq, tr, k = 0;
    tx_hold = 1'b1;
    push_tx(8'hE1);
    exp_op(OP_START, 8'h1E, 0); exp_op(OP_WRITE, 8'hE1, 0); exp_op(OP_STOP, 8'h00, 0);
    send_cmd(1'b0, 7'h0F, 8'd1);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); #1;
      if (obs_q.size() > ob) break;
    end
    repeat (6) @(negedge clk);
    rq = obs_q.size(); tr = n_txrd;
    repeat (5) @(negedge clk);
    checks++;
    if (obs_q.size() != rq || n_txrd != tr || busy !== 1'b1) begin
      errors++;
      $display("FAIL stall: got new reqs %0d new rd_en %0d busy %b, required 0 0 1", obs_q.size() - rq, n_txrd - tr, busy);
    end
    tx_hold = 1'b0;
    wait_fin("stall");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (ob + k < obs_q.size()) ? obs_q[ob + k] : '1;
      checks++;
      if (o !== e) begin errors++; $display("FAIL stall_op%0d: got op %0d wdata %02h, required op %0d wdata %02h", k, o.op, o.wdata, e.op, e.wdata); end
      k++;
    end
    checks++;
    if (n_done - d0 != 1 || n_req_long != 0) begin
      errors++;
      $display("FAIL stall_done: got done %0d long_req %0d, required 1 0", n_done - d0, n_req_long);
    end
  endtask

  task automatic test_reset_mid();
    int ob = obs_q.size();
    push_tx(8'hD1); push_tx(8'hD2);
    send_cmd(1'b0, 7'h40, 8'd2);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); #1;
      if (obs_q.size() - ob >= 2) break;
    end
    rstn = 1'b0;
    #1;
    checks++;
    if ({cmd_ready, busy, done, err, eng_req, tx_rd_en, tx_snapshot, tx_rollback, rx_wr_en,
         rx_snapshot, rx_rollback, retry_cnt, eng_op, eng_wdata, rx_wr_data, eng_nack_last} !== 32'h0) begin
      errors++;
      $display("FAIL midreset_outputs: got busy %b eng_req %b eng_op %0d wdata %02h, required all 0", busy, eng_req, eng_op, eng_wdata);
    end
    @(negedge clk);
    rstn = 1'b1;
    tx_clr = 1'b1;
    @(negedge clk);
    tx_clr = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || obs_q.size() - ob != 2 ||
        obs_q[ob].op !== OP_START || obs_q[ob + 1] !== op_t'({OP_WRITE, 8'hD1, 1'b0})) begin
      errors++;
      $display("FAIL midreset_after: got cmd_ready %b busy %b ops %0d, required 1 0 2 (no STOP)",
               cmd_ready, busy, obs_q.size() - ob);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_nack_retry();
    test_addr_fail();
    test_arb_read();
    test_fetch_stall();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
